// File: rtl/rom_arbiter_pkg.sv
// Shared constants and state encoding for the ROM arbiter.
package rom_arbiter_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = DATA_W / 8;

  localparam logic [DATA_W-1:0] ZeroWord    = '0;
  localparam logic              WriteEnable = 1'b1;
  localparam logic              RstEnable   = 1'b1;

  typedef enum logic [1:0] {
    RomArbArb  = 2'd0,
    RomArbGnt0 = 2'd1,
    RomArbGnt1 = 2'd2
  } rom_arb_state_e;
endpackage

// File: rtl/rom_arbiter_if.sv
// Bus bundle between two ROM masters, the arbiter and the ROM port.
interface rom_arbiter_if;
  import rom_arbiter_pkg::*;

  logic              m0_req_i, m0_we_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [DATA_W-1:0] m0_data_i;
  logic [SEL_W-1:0]  m0_sel_i;
  logic              m0_ack_o, m0_err_o;
  logic [DATA_W-1:0] m0_data_o;

  logic              m1_req_i, m1_we_i, m1_lock_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [DATA_W-1:0] m1_data_i;
  logic [SEL_W-1:0]  m1_sel_i;
  logic              m1_ack_o;
  logic [DATA_W-1:0] m1_data_o;

  logic              rom_we_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [DATA_W-1:0] rom_data_o;
  logic [SEL_W-1:0]  rom_sel_o;
  logic [DATA_W-1:0] rom_data_i;

  logic              halt_o, busy_o;

  // arbiter side
  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_data_i, m0_sel_i,
    output m0_ack_o, m0_err_o, m0_data_o,
    input  m1_req_i, m1_we_i, m1_lock_i, m1_addr_i, m1_data_i, m1_sel_i,
    output m1_ack_o, m1_data_o,
    output rom_we_o, rom_addr_o, rom_data_o, rom_sel_o,
    input  rom_data_i,
    output halt_o, busy_o
  );

  // masters + ROM side
  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_data_i, m0_sel_i,
    input  m0_ack_o, m0_err_o, m0_data_o,
    output m1_req_i, m1_we_i, m1_lock_i, m1_addr_i, m1_data_i, m1_sel_i,
    input  m1_ack_o, m1_data_o,
    input  rom_we_o, rom_addr_o, rom_data_o, rom_sel_o,
    output rom_data_i,
    input  halt_o, busy_o
  );
endinterface

// File: rtl/rom_arb_pick.sv
// Two-way round-robin pick. Lock hands the ROM to m1 exclusively;
// otherwise a sole requester wins and a tie goes to the master not served last.
module rom_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  input  logic lock,
  output logic gnt0,
  output logic gnt1
);
  // priority rule
  always_comb begin
    gnt0 = !lock && req0 && (!req1 || last);
    gnt1 = req1 && (lock || !req0 || !last);
  end
endmodule

// File: rtl/rom_arbiter.sv
// Two-master ROM arbiter/sequencer: one access per grant, one-cycle ack,
// m1 download lock with core halt request.
// Optional macro ROM_WR_PROTECT_EN: m0 writes are acked but suppressed, with m0_err_o.
module rom_arbiter
  import rom_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  rom_arbiter_if.slave bus
);
  rom_arb_state_e state, state_n;
  logic           last, last_n;
  logic           lock_r, lock_n;
  logic           gnt0, gnt1;

  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [SEL_W-1:0]  sel;
  logic [1:0]        ack;
  logic              err0;

  rom_arb_pick u_pick (
    .req0 (bus.m0_req_i),
    .req1 (bus.m1_req_i),
    .last (last),
    .lock (lock_r),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  // state, last-served and lock registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state  <= RomArbArb;
      last   <= 1'b1;
      lock_r <= 1'b0;
    end else begin
      state  <= state_n;
      last   <= last_n;
      lock_r <= lock_n;
    end
  end

  // next state and ROM port mux; everything idles at zero outside a grant
  always_comb begin
    state_n = state;
    last_n  = last;
    lock_n  = lock_r;
    we      = 1'b0;
    addr    = '0;
    wdata   = ZeroWord;
    sel     = '0;
    ack     = 2'b00;
    err0    = 1'b0;
    case (state)
      RomArbArb: begin
        if (gnt0)      state_n = RomArbGnt0;
        else if (gnt1) state_n = RomArbGnt1;
        // an idle m1 can release the lock by dropping m1_lock_i
        if (lock_r && !bus.m1_req_i) lock_n = bus.m1_lock_i;
      end
      RomArbGnt0: begin
        addr    = bus.m0_addr_i;
        wdata   = bus.m0_data_i;
        sel     = bus.m0_sel_i;
        ack[0]  = 1'b1;
        last_n  = 1'b0;
        state_n = RomArbArb;
`ifdef ROM_WR_PROTECT_EN
        we      = 1'b0;
        err0    = (bus.m0_we_i == WriteEnable);
`else
        we      = bus.m0_we_i;
`endif
      end
      RomArbGnt1: begin
        we      = bus.m1_we_i;
        addr    = bus.m1_addr_i;
        wdata   = bus.m1_data_i;
        sel     = bus.m1_sel_i;
        ack[1]  = 1'b1;
        last_n  = 1'b1;
        lock_n  = bus.m1_lock_i;
        state_n = RomArbArb;
      end
      default: state_n = RomArbArb;
    endcase
  end

  // output drive; read data is forwarded only to the master being acked
  always_comb begin
    bus.rom_we_o   = we;
    bus.rom_addr_o = addr;
    bus.rom_data_o = wdata;
    bus.rom_sel_o  = sel;
    bus.m0_ack_o   = ack[0];
    bus.m1_ack_o   = ack[1];
    bus.m0_err_o   = err0;
    bus.m0_data_o  = ack[0] ? bus.rom_data_i : ZeroWord;
    bus.m1_data_o  = ack[1] ? bus.rom_data_i : ZeroWord;
    bus.halt_o     = lock_r;
    bus.busy_o     = (state != RomArbArb);
  end
endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Two-master arbiter and sequencer for the shared instruction/data ROM.
- Master 0 (m0) is the core bus port. Master 1 (m1) is the debug/UART program downloader.
- Arbitrates round-robin, sequences one access per grant with a req/ack handshake, and drives the ROM write/read port.
- Supports a download lock that holds the ROM for m1 and raises a core halt request.

Parameters:
- ADDR_W, 32, address width (matches MemAddrBus).
- DATA_W, 32, data width (matches MemBus).
- SEL_W, 4, byte-select width (DATA_W/8).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- m0_req_i  in  1  m0 access request; held with its attributes until m0_ack_o.
- m0_we_i  in  1  m0 write enable.
- m0_addr_i  in  ADDR_W  m0 byte address.
- m0_data_i  in  DATA_W  m0 write data.
- m0_sel_i  in  SEL_W  m0 byte select.
- m0_ack_o  out  1  one-cycle access-complete strobe.
- m0_data_o  out  DATA_W  read data; valid only while m0_ack_o is high.
- m0_err_o  out  1  write rejected (see Optional Feature); tied to 0 when the feature is compiled out.
- m1_req_i, m1_we_i, m1_addr_i, m1_data_i, m1_sel_i, m1_ack_o, m1_data_o  as the m0 ports, for m1.
- m1_lock_i  in  1  m1 requests exclusive ownership (download burst).
- rom_we_o  out  1  ROM write enable.
- rom_addr_o  out  ADDR_W  ROM address.
- rom_data_o  out  DATA_W  ROM write data.
- rom_sel_o  out  SEL_W  ROM byte select.
- rom_data_i  in  DATA_W  ROM read data (combinational from rom_addr_o).
- halt_o  out  1  core halt request while the lock is held.
- busy_o  out  1  state is not ARB.

Behaviour:
- State machine:
  - States: ARB, GNT0, GNT1. Registered: state, last (last master served), lock_r.
  - Reset (async, any time, including mid-access): state=ARB, last=1, lock_r=0. Every output is 0; an in-flight access is dropped with no ack.
- ARB:
  - If lock_r=1: grant m1 only (m1_req_i -> GNT1); m0 waits.
  - Otherwise, if exactly one req is high: go to that master's GNT state.
  - If both are high: grant the master != last.
  - No req: stay in ARB.
  - All rom_* outputs are 0 in ARB.
- GNTx (exactly one cycle):
  - rom_* outputs are driven combinationally from master x's inputs.
  - mx_ack_o=1 and mx_data_o=rom_data_i.
  - Write lands at the next clk edge.
  - Next state is ARB; last<=x.
- Lock:
  - In GNT1, lock_r<=m1_lock_i.
  - In ARB with lock_r=1 and m1_req_i=0, lock_r<=m1_lock_i, so dropping the lock while idle releases it.
- Latency and throughput:
  - req to ack is 2 cycles minimum; each access costs 2 cycles, so peak is 1 access per 2 cycles per arbiter.
- Non-granted master:
  - ack=0 and data_o=0.
  - A req deasserted before ack is a protocol error; behaviour is undefined (no assertion required).
- Outputs:
  - halt_o = lock_r (registered).
  - busy_o = (state!=ARB).
- Starvation bound: without lock, each master waits at most one foreign access (4 cycles).

Optional Feature:
- Macro: ROM_WR_PROTECT_EN.
- Defined:
  - An m0 access with m0_we_i=1 is acked normally in GNT0, but rom_we_o is held at 0 and m0_err_o=1 during that ack cycle.
  - m1 writes are unaffected.
- Undefined: m0_err_o is tied to 0 and m0 writes pass through.

Decomposition:
- Constants come from the shared defines.v: MemAddrBus, MemBus, ZeroWord, WriteEnable, RstEnable.
- Add to defines.v:
  - RomArbStateBus (2 bits).
  - RomArbArb=2'd0, RomArbGnt0=2'd1, RomArbGnt1=2'd2.
- Sub-module rom_arb_pick: combinational two-way round-robin pick (req0, req1, last, lock -> gnt0, gnt1). Keeps the priority rule testable in isolation.

Test Plan:
- Reset mid-GNT1 write (m1 write 0xDEADBEEF to 0x10, rst pulses within the GNT1 cycle) -> ack never seen; rom_we_o=0 immediately; state ARB after release.
- m0 read only, address 0x8 -> m0_ack_o high on the 2nd cycle after req; m0_data_o=rom word 2; rom_addr_o=0x8 only in that cycle.
- m0 and m1 both requesting continuously after reset -> acks alternate m0, m1, m0, m1, one ack every 2 cycles, m0 first.
- m1 with m1_lock_i=1 doing 3 writes (sel=4'b0011, data 0x00001234) while m0 requests -> halt_o=1 from the cycle after the 1st GNT1; m0 gets no ack until the lock drops; the ROM low halfwords are updated and the high halfwords unchanged.
- ROM_WR_PROTECT_EN defined, m0 write 0xFFFFFFFF to 0x0 -> m0_ack_o=1 and m0_err_o=1; rom_we_o=0; a later read of 0x0 returns the original data.
- Without the macro, the same m0 write -> m0_err_o=0; a read returns 0xFFFFFFFF.
